// File: rtl/word_tx16_if.sv
// word_tx16_if: load/data request and serial status bundle for word_tx16.
// master drives load/D; slave (the transmitter) drives busy/TX/done.
interface word_tx16_if;
  logic        load;
  logic [15:0] D;
  logic        busy;
  logic        TX;
  logic        done;

  modport master (
    output load,
    output D,
    input  busy,
    input  TX,
    input  done
  );

  modport slave (
    input  load,
    input  D,
    output busy,
    output TX,
    output done
  );
endinterface

// File: rtl/word_tx16.sv
// word_tx16: framed serial transmitter for 16-bit words (start, D LSB first,
// optional even parity, stop). Ports: clk, rst_n (sync, active-low), bus (slave).
module word_tx16 #(
  parameter int BAUD_DIV  = 4,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  word_tx16_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  localparam logic [15:0] LP_LAST = 16'(BAUD_DIV - 1);

  state_t      r_state;
  logic [15:0] r_shift;
  logic [15:0] r_baud;
  logic [3:0]  r_bit;
  logic        r_par;
  logic        r_tx;
  logic        r_busy;
  logic        r_done;
  logic        w_last;

  assign w_last = (r_baud == LP_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_shift <= '0;
      r_baud  <= '0;
      r_bit   <= '0;
      r_par   <= 1'b0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state != S_IDLE)
        r_baud <= w_last ? '0 : r_baud + 16'd1;
      unique case (r_state)
        S_IDLE: begin
          if (bus.load) begin
            r_shift <= bus.D;
            r_par   <= PARITY_EN & (^bus.D);
            r_baud  <= '0;
            r_bit   <= '0;
            r_tx    <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (w_last) begin
            r_tx    <= r_shift[0];
            r_state <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_last) begin
            r_shift <= {1'b0, r_shift[15:1]};
            if (r_bit == 4'd15) begin
              r_bit <= '0;
              if (PARITY_EN) begin
                r_tx    <= r_par;
                r_state <= S_PARITY;
              end else begin
                r_tx    <= 1'b1;
                r_state <= S_STOP;
              end
            end else begin
              r_bit <= r_bit + 4'd1;
              // next bit is the one about to shift into position 0
              r_tx  <= r_shift[1];
            end
          end
        end
        S_PARITY: begin
          if (w_last) begin
            r_tx    <= 1'b1;
            r_state <= S_STOP;
          end
        end
        S_STOP: begin
          if (w_last) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.TX   = r_tx;
  assign bus.busy = r_busy;
  assign bus.done = r_done;

endmodule
